// File: rtl/tlc_pkg.sv
// Shared defaults for the traffic-light controller slice: sensor conditioner
// timing parameters, also used by the controller bench.
package tlc_pkg;

   localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;
   localparam int unsigned STUCK_CYCLES_DEF    = 60000;
   localparam int unsigned CNT_W_DEF           = 16;

endpackage : tlc_pkg

// File: rtl/sensor_channel.sv
// One vehicle-loop channel: two-flop synchronizer, debounce, request latch
// and stuck-high monitor.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   raw          : asynchronous, bouncy detector input
//   clr          : serve level from the controller's green; clears req
//   deb          : debounced detector level
//   req          : latched request, held until served
//   fault        : detector stuck high
module sensor_channel
   import tlc_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned STUCK_CYCLES    = STUCK_CYCLES_DEF,
   parameter int unsigned CNT_W           = CNT_W_DEF
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw,
   input  logic clr,
   output logic deb,
   output logic req,
   output logic fault
);

   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] STUCK_LIM = CNT_W'(STUCK_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic             s1;
   logic             s2;
   logic [CNT_W-1:0] dcnt;
   logic [CNT_W-1:0] scnt;

   logic             deb_nxt;
   logic [CNT_W-1:0] dcnt_nxt;
   logic [CNT_W-1:0] scnt_nxt;
   logic             rise_c;
   logic             req_nxt;
   logic             fault_nxt;

   // Next-state: debounce, latch and stuck counter.
   always_comb begin
      deb_nxt   = deb;
      dcnt_nxt  = '0;
      scnt_nxt  = '0;
      req_nxt   = req;
      fault_nxt = 1'b0;

      if (s2 != deb) begin
         if (dcnt == DEB_LAST) begin
            deb_nxt = s2;
         end else begin
            dcnt_nxt = dcnt + CNT_ONE;
         end
      end

      // Rise is taken on the same edge deb is accepted, so clr on that edge wins.
      rise_c = deb_nxt & ~deb;
      if (clr) begin
         req_nxt = 1'b0;
      end else if (rise_c) begin
         req_nxt = 1'b1;
      end

      // Saturating count of consecutive debounced-high cycles.
      if (deb) begin
         scnt_nxt  = (scnt == STUCK_LIM) ? scnt : scnt + CNT_ONE;
         fault_nxt = (scnt_nxt == STUCK_LIM);
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         deb   <= 1'b0;
         dcnt  <= '0;
         req   <= 1'b0;
         scnt  <= '0;
         fault <= 1'b0;
      end else begin
         s1    <= raw;
         s2    <= s1;
         deb   <= deb_nxt;
         dcnt  <= dcnt_nxt;
         req   <= req_nxt;
         scnt  <= scnt_nxt;
         fault <= fault_nxt;
      end
   end

endmodule : sensor_channel

// File: rtl/vehicle_sensor_conditioner.sv
// Conditions both vehicle-loop detectors into the controller's Sa/Sb requests.
// Any stuck detector forces both requests high (fixed-time cycling).
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   raw_a, raw_b   : raw detector inputs
//   clr_a, clr_b   : serve levels from the controller's Ga/Gb
//   sa, sb         : registered conditioned requests
//   fault_a/_b     : registered stuck-high flags
module vehicle_sensor_conditioner
   import tlc_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned STUCK_CYCLES    = STUCK_CYCLES_DEF,
   parameter int unsigned CNT_W           = CNT_W_DEF
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw_a,
   input  logic raw_b,
   input  logic clr_a,
   input  logic clr_b,
   output logic sa,
   output logic sb,
   output logic fault_a,
   output logic fault_b
);

   logic deb_a;
   logic deb_b;
   logic req_a;
   logic req_b;
   logic any_fault_c;

   sensor_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .STUCK_CYCLES    (STUCK_CYCLES),
      .CNT_W           (CNT_W)
   ) u_ch_a (
      .clk     (clk),
      .reset_n (reset_n),
      .raw     (raw_a),
      .clr     (clr_a),
      .deb     (deb_a),
      .req     (req_a),
      .fault   (fault_a)
   );

   sensor_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .STUCK_CYCLES    (STUCK_CYCLES),
      .CNT_W           (CNT_W)
   ) u_ch_b (
      .clk     (clk),
      .reset_n (reset_n),
      .raw     (raw_b),
      .clr     (clr_b),
      .deb     (deb_b),
      .req     (req_b),
      .fault   (fault_b)
   );

   assign any_fault_c = fault_a | fault_b;

   // Output registers: level presence, latched request, or fault override.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sa <= 1'b0;
         sb <= 1'b0;
      end else begin
         sa <= deb_a | req_a | any_fault_c;
         sb <= deb_b | req_b | any_fault_c;
      end
   end

endmodule : vehicle_sensor_conditioner

// File: tb/tb_vehicle_sensor_conditioner.sv
// Self-checking bench for vehicle_sensor_conditioner: directed scenarios plus
// randomized detector/serve traffic, all checked against a behavioural model.
module tb_vehicle_sensor_conditioner;

   localparam int unsigned D = 4;
   localparam int unsigned S = 20;
   localparam int unsigned W = 8;

   logic clk = 1'b0;
   logic reset_n;
   logic raw_a, raw_b, clr_a, clr_b;
   logic sa, sb, fault_a, fault_b;

   int errors = 0;
   int checks = 0;
   bit mon_en = 1'b0;

   vehicle_sensor_conditioner #(
      .DEBOUNCE_CYCLES (D),
      .STUCK_CYCLES    (S),
      .CNT_W           (W)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .raw_a   (raw_a),
      .raw_b   (raw_b),
      .clr_a   (clr_a),
      .clr_b   (clr_b),
      .sa      (sa),
      .sb      (sb),
      .fault_a (fault_a),
      .fault_b (fault_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Behavioural model: per channel, the synchronized sample history, the
   // accepted level, how long the synced level has disagreed with it, the
   // latched request and how long the accepted level has been high.
   typedef struct {
      bit s1;
      bit s2;
      bit deb;
      int disagree;
      bit req;
      int high_len;
      bit fault;
   } chan_m_t;

   chan_m_t ma, mb;
   bit m_sa, m_sb;

   function automatic chan_m_t model_step(chan_m_t c, bit raw, bit clr);
      chan_m_t n = c;
      n.s1 = raw;
      n.s2 = c.s1;
      if (c.s2 == c.deb)               n.disagree = 0;
      else if (c.disagree + 1 == int'(D)) begin
         n.deb = c.s2;
         n.disagree = 0;
      end else                         n.disagree = c.disagree + 1;
      if (clr)                         n.req = 1'b0;
      else if (n.deb && !c.deb)        n.req = 1'b1;
      n.high_len = c.deb ? c.high_len + 1 : 0;
      n.fault    = c.deb && (n.high_len >= int'(S));
      return n;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ma   = '{default: 0};
         mb   = '{default: 0};
         m_sa = 1'b0;
         m_sb = 1'b0;
      end else begin
         m_sa = ma.deb | ma.req | ma.fault | mb.fault;
         m_sb = mb.deb | mb.req | ma.fault | mb.fault;
         ma   = model_step(ma, bit'(raw_a), bit'(clr_a));
         mb   = model_step(mb, bit'(raw_b), bit'(clr_b));
      end
   end

   // Continuous comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("mon_sa",      32'(sa),      32'(m_sa));
         chk("mon_sb",      32'(sb),      32'(m_sb));
         chk("mon_fault_a", 32'(fault_a), 32'(ma.fault));
         chk("mon_fault_b", 32'(fault_b), 32'(mb.fault));
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_both();
      raw_a = 1'b0;
      raw_b = 1'b0;
      step(12);
      clr_a = 1'b1;
      clr_b = 1'b1;
      step(1);
      clr_a = 1'b0;
      clr_b = 1'b0;
      step(3);
   endtask

   initial begin
      int rem_a, rem_b;
      raw_a   = 1'b0;
      raw_b   = 1'b0;
      clr_a   = 1'b0;
      clr_b   = 1'b0;
      reset_n = 1'b0;
      #1;
      chk("rst_sa", 32'(sa), 32'd0);
      chk("rst_fault_b", 32'(fault_b), 32'd0);
      step(2);
      reset_n = 1'b1;
      mon_en  = 1'b1;

      // Clean press: raw_a first sampled at E1, sa rises at E7.
      raw_a = 1'b1;
      step(6);
      chk("press_sa_e6", 32'(sa), 32'd0);
      step(1);
      chk("press_sa_e7", 32'(sa), 32'd1);
      chk("press_sb_e7", 32'(sb), 32'd0);
      step(3);
      raw_a = 1'b0;
      step(10);
      clr_a = 1'b1;
      step(1);
      clr_a = 1'b0;
      step(3);

      // Glitch rejection on B.
      repeat (4) begin
         raw_b = 1'b1;
         step(3);
         raw_b = 1'b0;
         step(2);
      end
      step(8);
      chk("glitch_sb", 32'(sb), 32'd0);
      chk("glitch_dcnt_b", 32'(dut.u_ch_b.dcnt), 32'd0);

      // Latch and clear.
      raw_a = 1'b1;
      step(6);
      raw_a = 1'b0;
      step(20);
      chk("latch_sa_held", 32'(sa), 32'd1);
      clr_a = 1'b1;
      step(1);
      clr_a = 1'b0;
      chk("latch_sa_p1", 32'(sa), 32'd1);
      step(1);
      chk("latch_sa_p2", 32'(sa), 32'd0);
      step(3);

      // Rise coinciding with clr: clr_a seen on exactly the E6 edge.
      raw_a = 1'b1;
      step(5);
      clr_a = 1'b1;
      step(1);
      clr_a = 1'b0;
      chk("coinc_req_a", 32'(dut.u_ch_a.req), 32'd0);
      raw_a = 1'b0;
      step(12);
      chk("coinc_sa", 32'(sa), 32'd0);

      // Stuck detector B: deb_b at E6, fault_b at E26, forced outputs at E27.
      raw_b = 1'b1;
      step(25);
      chk("stuck_fault_b_e25", 32'(fault_b), 32'd0);
      step(1);
      chk("stuck_fault_b_e26", 32'(fault_b), 32'd1);
      chk("stuck_sa_e26", 32'(sa), 32'd0);
      step(1);
      chk("stuck_sa_e27", 32'(sa), 32'd1);
      chk("stuck_sb_e27", 32'(sb), 32'd1);
      step(5);
      raw_b = 1'b0;
      step(12);
      chk("stuck_fault_b_clr", 32'(fault_b), 32'd0);
      chk("stuck_sa_rel", 32'(sa), 32'd0);
      chk("stuck_sb_req", 32'(sb), 32'd1);

      // Reset mid-operation with fault_a set and req_b still latched.
      raw_a = 1'b1;
      step(30);
      chk("mid_fault_a_pre", 32'(fault_a), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_sa", 32'(sa), 32'd0);
      chk("mid_rst_sb", 32'(sb), 32'd0);
      chk("mid_rst_fault_a", 32'(fault_a), 32'd0);
      chk("mid_rst_fault_b", 32'(fault_b), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      step(6);
      chk("mid_redeb_sa_e6", 32'(sa), 32'd0);
      step(1);
      chk("mid_redeb_sa_e7", 32'(sa), 32'd1);
      clear_both();

      // Simultaneous channels.
      raw_a = 1'b1;
      raw_b = 1'b1;
      step(6);
      chk("sim_sa_e6", 32'(sa), 32'd0);
      chk("sim_sb_e6", 32'(sb), 32'd0);
      step(1);
      chk("sim_sa_e7", 32'(sa), 32'd1);
      chk("sim_sb_e7", 32'(sb), 32'd1);
      clear_both();

      // Randomized detector and serve traffic.
      rem_a = 0;
      rem_b = 0;
      for (int i = 0; i < 3000; i++) begin
         if (rem_a == 0) begin
            raw_a = ~raw_a;
            rem_a = int'($urandom_range(1, 28));
         end
         if (rem_b == 0) begin
            raw_b = ~raw_b;
            rem_b = int'($urandom_range(1, 28));
         end
         rem_a--;
         rem_b--;
         clr_a = ($urandom_range(0, 9) == 0);
         clr_b = ($urandom_range(0, 9) == 0);
         step(1);
      end
      clr_a = 1'b0;
      clr_b = 1'b0;
      step(5);

      mon_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_vehicle_sensor_conditioner

// File: doc/vehicle_sensor_conditioner.md
# vehicle_sensor_conditioner

Conditions the two raw vehicle-loop detector inputs for the intersection controller and drives its `Sa`/`Sb` request inputs. Each channel is synchronized, debounced and latched until served, and watched for a stuck-high detector. On any detector fault, both requests are forced high, which puts the controller into fixed-time cycling. Sits directly upstream of the traffic light controller. The controller's green outputs feed back to clear the latched requests.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive synchronized cycles a new level must hold before it is accepted. Legal range is 2 to 2^CNT_W-1.
- `STUCK_CYCLES`, default 60000: consecutive debounced-high cycles that declare a stuck detector. Must be greater than `DEBOUNCE_CYCLES` and no more than 2^CNT_W-1.
- `CNT_W`, default 16: width of the debounce and stuck counters.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `raw_a` in 1: raw detector for approach A. Asynchronous and bouncy.
- `raw_b` in 1: raw detector for approach B. Asynchronous and bouncy.
- `clr_a` in 1: serve strobe/level for A, driven from the controller's `Ga`. Clears the A latch.
- `clr_b` in 1: serve strobe/level for B, driven from the controller's `Gb`. Clears the B latch.
- `sa` out 1: conditioned request for A. Registered. Feeds the controller's `Sa`.
- `sb` out 1: conditioned request for B. Registered. Feeds the controller's `Sb`.
- `fault_a` out 1: detector A stuck high. Registered.
- `fault_b` out 1: detector B stuck high. Registered.

## Operation
Each channel runs the following, identically and independently.
- **Sync:** two-flop synchronizer `raw -> s1 -> s2`.
- **Debounce:**
  - `deb` level register and `dcnt` counter.
  - If `s2 == deb`: `dcnt <= 0`.
  - Else if `dcnt == DEBOUNCE_CYCLES-1`: `deb <= s2`, `dcnt <= 0`.
  - Else: `dcnt <= dcnt+1`.
  - A pulse or gap shorter than `DEBOUNCE_CYCLES` synchronized cycles is rejected.
- **Request latch `req`** (priority order):
  - `clr` high: `req <= 0`.
  - Else rising edge of `deb` (`deb` went 0 to 1 this cycle): `req <= 1`.
  - Else hold.
  - A simultaneous clr and rise resolves to clr: a car arriving during its own green counts as served.
- **Stuck monitor:**
  - `scnt` counts consecutive cycles with `deb == 1` and saturates at `STUCK_CYCLES`.
  - `deb == 0` sets `scnt <= 0` and `fault <= 0`.
  - `fault <= 1` when `scnt` reaches `STUCK_CYCLES`. It stays set while `deb` stays high.
- **Output:**
  - `any_fault = fault_a | fault_b`.
  - `sa <= deb_a | req_a | any_fault`.
  - `sb <= deb_b | req_b | any_fault`.
  - `deb` supplies the level presence needed for the controller's extend decision. `req` keeps a car that has already left still requesting until it is served.

## Timing
- **Reset:** asynchronous. All flops are cleared: `s1`, `s2`, `deb`, `dcnt`, `req`, `scnt`, `fault`, `sa`, `sb`, `fault_a`, `fault_b` all go to 0. Reset mid-debounce or mid-fault discards all history.
- **Latency:**
  - `raw` is first sampled high at edge E1 and then held.
  - `s2 = 1` at E2.
  - `deb = 1` at E(2+DEBOUNCE_CYCLES).
  - `sa = 1` at E(3+DEBOUNCE_CYCLES).
  - Falling latency is the same, provided `req` and faults are clear.
- **Fault latency:**
  - `fault` asserts STUCK_CYCLES edges after `deb` rises.
  - `sa`/`sb` are forced high on the following edge.
  - Fault clears one edge after `deb` falls. The forced outputs release one edge after that.
- **Clear:** `clr` is sampled each edge, so `req` falls on the edge after `clr` is seen. `sa` reflects the change one further edge later, unless `deb` or a fault holds it high.
- **Counters:** unsigned `CNT_W` bits. Neither counter ever wraps. `dcnt` resets at its limit and `scnt` saturates.

## Structure
- **Shared package `tlc_pkg`:** default values for `DEBOUNCE_CYCLES`, `STUCK_CYCLES` and `CNT_W`, shared with the controller bench.
- **Sub-module `sensor_channel`:** synchronizer, debounce, latch and stuck monitor. Ports are `clk`, `reset_n`, `raw`, `clr`, `deb`, `req`, `fault`.
- **Top level:** instantiates `sensor_channel` twice and adds the fault OR and the output registers.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`, `STUCK_CYCLES=20`, `CNT_W=8`.
1. **Clean press:** hold `raw_a=1` from E1 -> `sa` rises at E7. `sb` stays 0 and both faults stay 0.
2. **Glitch rejection:** pulse `raw_b` high for 3 cycles, then low for 2 cycles, repeated 4 times -> `sb` never asserts and `dcnt_b` returns to 0.
3. **Latch and clear:** pulse `raw_a` high for 6 cycles, then release -> `sa` stays 1 after `deb` falls. Assert `clr_a` for 1 cycle -> `sa` drops 2 edges later. A rise coinciding with `clr_a` high -> `req_a` stays 0.
4. **Stuck detector:** hold `raw_b=1` -> `fault_b=1` 20 edges after `deb_b` rises, then `sa=sb=1` on the next edge. Release `raw_b` -> `fault_b` clears and both outputs return to their normal values.
5. **Reset mid-operation:** with `fault_a=1` and `req_b=1`, pulse `reset_n` low asynchronously between edges -> all outputs go to 0 immediately. After release, a held `raw_a` is re-debounced in full (E7 latency).
6. **Simultaneous channels:** assert `raw_a` and `raw_b` on the same cycle -> `sa` and `sb` rise on the same edge (E7).
